tick_rate_ctrl: RTL and testbench

//  Upstream pacing stage for the LED scanner FSM. Produces a one-cycle TICK

---
 rtl/tick_rate_ctrl_pkg.sv | 27 ++
 rtl/tick_rate_ctrl_key_debounce.sv | 46 ++++
 rtl/tick_rate_ctrl.sv | 102 ++++++++++
 tb/tb_tick_rate_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_ctrl_pkg.sv
// Shared defaults and helpers for the LED scanner pacing stage.
// Key polarity and default rates match the scanner top level.
package tick_rate_ctrl_pkg;

  localparam int DEF_BASE_DIV     = 781250;
  localparam int DEF_N_LEVELS     = 8;
  localparam int DEF_RESET_LEVEL  = 3;
  localparam int DEF_DEBOUNCE_CYC = 500000;

  // Push-buttons pull low when pressed
  localparam logic KEY_ACTIVE = 1'b0;
  localparam logic KEY_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_FASTER,
    LVL_SLOWER
  } lvl_op_e;

  // Simultaneous presses cancel out
  function automatic lvl_op_e decode_keys(input logic fast, input logic slow);
    if (fast && !slow)      return LVL_FASTER;
    else if (slow && !fast) return LVL_SLOWER;
    else                    return LVL_HOLD;
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_key_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter and a one-cycle
// press pulse on the accepted released->pressed transition.
module key_debounce
  import tick_rate_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DW           = $clog2(DEF_DEBOUNCE_CYC + 1)
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key_raw,
  output logic press
);

  logic          sync1;
  logic          sync2;
  logic          accepted;
  logic [DW-1:0] dcnt;
  logic          settle;

  assign settle = (sync2 != accepted) && (dcnt == DW'(DEBOUNCE_CYC - 1));

  // Any return to the accepted value restarts the stability count
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1    <= KEY_IDLE;
      sync2    <= KEY_IDLE;
      accepted <= KEY_IDLE;
      dcnt     <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= settle && (sync2 == KEY_ACTIVE);
      if (sync2 == accepted) begin
        dcnt <= '0;
      end else if (settle) begin
        accepted <= sync2;
        dcnt     <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Pacing stage for the LED scanner: speed level register stepped by two
// debounced keys, and a period counter producing the one-cycle TICK strobe.
module tick_rate_ctrl
  import tick_rate_ctrl_pkg::*;
#(
  parameter int BASE_DIV     = DEF_BASE_DIV,
  parameter int N_LEVELS     = DEF_N_LEVELS,
  parameter int RESET_LEVEL  = DEF_RESET_LEVEL,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = 27,
  parameter int LVL_W        = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RUN,
  input  logic             KEY_FAST,
  input  logic             KEY_SLOW,
  output logic             TICK,
  output logic [LVL_W-1:0] LEVEL,
  output logic             LEVEL_CHG
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);

  logic             press_fast;
  logic             press_slow;
  lvl_op_e          op;
  logic             lvl_change;
  logic [LVL_W-1:0] lvl_next;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DW(DBW)) u_key_fast (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .key_raw (KEY_FAST),
    .press   (press_fast)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DW(DBW)) u_key_slow (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .key_raw (KEY_SLOW),
    .press   (press_slow)
  );

  // Presses at either end of the range saturate silently
  always_comb begin
    op         = decode_keys(press_fast, press_slow);
    lvl_next   = LEVEL;
    lvl_change = 1'b0;
    case (op)
      LVL_FASTER: begin
        if (LEVEL != '0) begin
          lvl_next   = LEVEL - LVL_W'(1);
          lvl_change = 1'b1;
        end
      end
      LVL_SLOWER: begin
        if (LEVEL != LVL_W'(N_LEVELS - 1)) begin
          lvl_next   = LEVEL + LVL_W'(1);
          lvl_change = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign div = CNT_W'(BASE_DIV) << LEVEL;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      LEVEL     <= LVL_W'(RESET_LEVEL);
      LEVEL_CHG <= 1'b0;
    end else begin
      LEVEL     <= lvl_next;
      LEVEL_CHG <= lvl_change;
    end
  end

  // A level change restarts the period and wins over a terminal count
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (lvl_change) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (RUN) begin
      if (cnt == div - CNT_W'(1)) begin
        cnt  <= '0;
        TICK <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        TICK <= 1'b0;
      end
    end else begin
      TICK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl with small rates (BASE_DIV=4, 4 levels,
// reset level 1, 3-cycle debounce); expected timings are hand-derived.
module tb_tick_rate_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       RUN;
  logic       KEY_FAST;
  logic       KEY_SLOW;
  logic       TICK;
  logic [1:0] LEVEL;
  logic       LEVEL_CHG;

  int total    = 0;
  int bad      = 0;
  int chgCount = 0;
  int base;
  int n;
  int seen;

  tick_rate_ctrl #(
    .BASE_DIV     (4),
    .N_LEVELS     (4),
    .RESET_LEVEL  (1),
    .DEBOUNCE_CYC (3),
    .CNT_W        (6),
    .LVL_W        (2)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .RUN       (RUN),
    .KEY_FAST  (KEY_FAST),
    .KEY_SLOW  (KEY_SLOW),
    .TICK      (TICK),
    .LEVEL     (LEVEL),
    .LEVEL_CHG (LEVEL_CHG)
  );

  always #5 CLK = ~CLK;

  // Count LEVEL_CHG pulses mid-cycle
  always @(negedge CLK) if (LEVEL_CHG === 1'b1) chgCount++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic kf, input logic ks);
    RUN      = run;
    KEY_FAST = kf;
    KEY_SLOW = ks;
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      cycle(1);
      cycles++;
    end while (TICK !== 1'b1 && cycles < 200);
  endtask

  task automatic syncTick(input string tag);
    int c;
    waitTick(c);
    checkOutput(tag, TICK, 1);
  endtask

  task automatic pressKey(input logic fast);
    if (fast) KEY_FAST = 1'b0;
    else      KEY_SLOW = 1'b0;
    cycle(10);
    if (fast) KEY_FAST = 1'b1;
    else      KEY_SLOW = 1'b1;
    cycle(10);
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b1);
    RSTn = 1'b0;
    cycle(2);
    checkOutput("rst_tick", TICK, 0);
    checkOutput("rst_level", LEVEL, 1);
    checkOutput("rst_chg", LEVEL_CHG, 0);

    // 1: level 1 free-running, period 8, first tick 8 cycles after release
    RSTn = 1'b1;
    waitTick(n); checkOutput("t1_first", n, 8);
    waitTick(n); checkOutput("t1_period", n, 8);
    checkOutput("t1_level", LEVEL, 1);

    // 2: clean fast press held 20 cycles
    base = chgCount;
    KEY_FAST = 1'b0;
    cycle(5);
    checkOutput("t2_level_pre", LEVEL, 1);
    checkOutput("t2_chg_pre", LEVEL_CHG, 0);
    cycle(1);
    checkOutput("t2_level", LEVEL, 0);
    checkOutput("t2_chg", LEVEL_CHG, 1);
    cycle(1);
    checkOutput("t2_chg_end", LEVEL_CHG, 0);
    waitTick(n); checkOutput("t2_first", n, 3);
    waitTick(n); checkOutput("t2_period", n, 4);
    cycle(6);
    KEY_FAST = 1'b1;
    cycle(10);
    checkOutput("t2_one_press", chgCount - base, 1);
    checkOutput("t2_level_hold", LEVEL, 0);
    syncTick("t2_sync");
    waitTick(n); checkOutput("t2_period2", n, 4);

    // 3: bouncing slow press, then saturation at level 3
    base = chgCount;
    KEY_SLOW = 1'b0; cycle(1);
    KEY_SLOW = 1'b1; cycle(1);
    KEY_SLOW = 1'b0; cycle(1);
    KEY_SLOW = 1'b1; cycle(1);
    KEY_SLOW = 1'b0;
    cycle(5);
    checkOutput("t3_level_pre", LEVEL, 0);
    checkOutput("t3_chg_pre", LEVEL_CHG, 0);
    cycle(1);
    checkOutput("t3_level", LEVEL, 1);
    checkOutput("t3_chg", LEVEL_CHG, 1);
    waitTick(n); checkOutput("t3_first", n, 8);
    cycle(4);
    KEY_SLOW = 1'b1;
    cycle(10);
    checkOutput("t3_one_press", chgCount - base, 1);
    pressKey(1'b0);
    checkOutput("t3_level2", LEVEL, 2);
    pressKey(1'b0);
    checkOutput("t3_level3", LEVEL, 3);
    base = chgCount;
    pressKey(1'b0);
    checkOutput("t3_sat_level", LEVEL, 3);
    checkOutput("t3_sat_chg", chgCount - base, 0);
    syncTick("t3_sync");
    waitTick(n); checkOutput("t3_period32", n, 32);

    // 4: pause at cnt=5 for 10 cycles at level 1
    pressKey(1'b1);
    pressKey(1'b1);
    checkOutput("t4_level", LEVEL, 1);
    syncTick("t4_sync");
    cycle(5);
    checkOutput("t4_cnt_pre", dut.cnt, 5);
    RUN = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      if (TICK === 1'b1) seen++;
    end
    checkOutput("t4_no_tick", seen, 0);
    checkOutput("t4_cnt_held", dut.cnt, 5);
    RUN = 1'b1;
    waitTick(n); checkOutput("t4_resume", n, 3);
    waitTick(n); checkOutput("t4_period", n, 8);

    // 5: both keys in the same cycle
    base = chgCount;
    KEY_FAST = 1'b0;
    KEY_SLOW = 1'b0;
    cycle(6);
    checkOutput("t5_level", LEVEL, 1);
    checkOutput("t5_chg", LEVEL_CHG, 0);
    waitTick(n); checkOutput("t5_phase", n, 2);
    KEY_FAST = 1'b1;
    KEY_SLOW = 1'b1;
    waitTick(n); checkOutput("t5_period", n, 8);
    waitTick(n); checkOutput("t5_period2", n, 8);
    checkOutput("t5_no_chg", chgCount - base, 0);

    // 6: reset mid-operation at level 3, cnt 20
    pressKey(1'b0);
    pressKey(1'b0);
    checkOutput("t6_level_pre", LEVEL, 3);
    syncTick("t6_sync");
    cycle(20);
    checkOutput("t6_cnt_pre", dut.cnt, 20);
    RSTn = 1'b0;
    #1;
    checkOutput("t6_tick", TICK, 0);
    checkOutput("t6_level", LEVEL, 1);
    checkOutput("t6_cnt", dut.cnt, 0);
    checkOutput("t6_chg", LEVEL_CHG, 0);
    cycle(3);
    RSTn = 1'b1;
    waitTick(n); checkOutput("t6_first", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
